// File: rtl/pig_game_ctrl.sv
// Running Pig game control: key edge detection, game-state sequencing,
// lane tracking, speed-dependent step tick and score keeping.
module pig_game_ctrl #(
    parameter int unsigned LANES    = 3,
    parameter int unsigned STEP_DIV = 2500000,
    parameter int unsigned SCORE_W  = 16
) (
    input  logic               clk25,
    input  logic               clr,
    input  logic               left,
    input  logic               right,
    input  logic               start,
    input  logic               ret,
    input  logic [2:0]         mode,
    input  logic               collide,
    output logic [1:0]         state,
    output logic [1:0]         lane,
    output logic [SCORE_W-1:0] score,
    output logic               step,
    output logic [2:0]         speed
);

    localparam int unsigned CNT_W = $clog2(STEP_DIV);
    localparam logic [1:0] LANE_MID = 2'(LANES / 2);
    localparam logic [1:0] LANE_MAX = 2'(LANES - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_OVER  = 2'b11
    } state_t;

    state_t           st;
    logic             left_q;
    logic             right_q;
    logic             start_q;
    logic             ret_q;
    logic [CNT_W-1:0] cnt;

    logic             left_ev_c;
    logic             right_ev_c;
    logic             start_ev_c;
    logic             ret_ev_c;
    logic             mode_ok_c;
    logic [CNT_W-1:0] last_c;

    // Rising-edge events: a held key yields one event.
    assign left_ev_c  = left  & ~left_q;
    assign right_ev_c = right & ~right_q;
    assign start_ev_c = start & ~start_q;
    assign ret_ev_c   = ret   & ~ret_q;

    assign mode_ok_c = (mode >= 3'd1) && (mode <= 3'd5);

    // Terminal count of the step period; speed is always 1..5.
    assign last_c = CNT_W'((STEP_DIV >> (speed - 3'd1)) - 32'd1);

    assign state = st;

    always_ff @(posedge clk25 or negedge clr) begin
        if (!clr) begin
            st      <= S_IDLE;
            lane    <= LANE_MID;
            score   <= '0;
            step    <= 1'b0;
            speed   <= 3'd1;
            cnt     <= '0;
            left_q  <= 1'b0;
            right_q <= 1'b0;
            start_q <= 1'b0;
            ret_q   <= 1'b0;
        end else begin
            left_q  <= left;
            right_q <= right;
            start_q <= start;
            ret_q   <= ret;
            step    <= 1'b0;

            case (st)
                S_IDLE: begin
                    if (mode_ok_c) begin
                        speed <= mode;
                    end
                    if (start_ev_c) begin
                        st    <= S_RUN;
                        score <= '0;
                        lane  <= LANE_MID;
                        cnt   <= '0;
                    end
                end

                S_RUN: begin
                    // Collision wins over every other action in the cycle.
                    if (collide) begin
                        st <= S_OVER;
                    end else if (ret_ev_c) begin
                        st <= S_PAUSE;
                    end else begin
                        if (left_ev_c && !right_ev_c) begin
                            if (lane != 2'd0) begin
                                lane <= lane - 2'd1;
                            end
                        end else if (right_ev_c && !left_ev_c) begin
                            if (lane != LANE_MAX) begin
                                lane <= lane + 2'd1;
                            end
                        end

                        if (cnt == last_c) begin
                            cnt  <= '0;
                            step <= 1'b1;
                            if (score != SCORE_MAX) begin
                                score <= score + SCORE_W'(1);
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end

                S_PAUSE: begin
                    if (ret_ev_c) begin
                        st <= S_RUN;
                    end
                end

                S_OVER: begin
                    if (mode_ok_c) begin
                        speed <= mode;
                    end
                    if (start_ev_c) begin
                        st    <= S_RUN;
                        score <= '0;
                        lane  <= LANE_MID;
                        cnt   <= '0;
                    end else if (ret_ev_c) begin
                        st <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pig_game_ctrl.sv
// Scoreboard bench for pig_game_ctrl: stimulus queues expected snapshots
// tagged with a clock-edge index; a monitor pops and compares them.
module tb_pig_game_ctrl;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_PAUSE = 2'b10;
    localparam logic [1:0] ST_OVER  = 2'b11;

    // mask bits: [4] state, [3] lane, [2] score, [1] step, [0] speed
    localparam logic [4:0] M_ALL = 5'b11111;
    localparam logic [4:0] M_SL  = 5'b11000;

    typedef struct {
        int          at;
        string       name;
        logic [4:0]  mask;
        logic [1:0]  st;
        logic [1:0]  ln;
        logic [15:0] sc;
        logic        stp;
        logic [2:0]  spd;
    } exp_t;

    logic        clk25;
    logic        clr;
    logic        left;
    logic        right;
    logic        start;
    logic        ret;
    logic [2:0]  mode;
    logic        collide;
    logic [1:0]  state;
    logic [1:0]  lane;
    logic [15:0] score;
    logic        step;
    logic [2:0]  speed;

    exp_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   b;

    pig_game_ctrl #(
        .LANES   (3),
        .STEP_DIV(16),
        .SCORE_W (16)
    ) dut (
        .clk25  (clk25),
        .clr    (clr),
        .left   (left),
        .right  (right),
        .start  (start),
        .ret    (ret),
        .mode   (mode),
        .collide(collide),
        .state  (state),
        .lane   (lane),
        .score  (score),
        .step   (step),
        .speed  (speed)
    );

    initial begin
        clk25 = 1'b0;
        forever #5 clk25 = ~clk25;
    end

    initial begin
        forever begin
            @(posedge clk25);
            cyc++;
        end
    end

    function automatic void push(input int at, input string name, input logic [4:0] mask,
                                 input logic [1:0] st, input logic [1:0] ln,
                                 input logic [15:0] sc, input logic stp, input logic [2:0] spd);
        exp_t e;
        e.at = at; e.name = name; e.mask = mask; e.st = st; e.ln = ln;
        e.sc = sc; e.stp = stp; e.spd = spd;
        exp_q.push_back(e);
    endfunction

    // Monitor: compares every snapshot due at this edge (or at an async clear).
    initial begin
        exp_t e;
        logic ok;
        forever begin
            @(posedge clk25 or negedge clr);
            #1;
            while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
                e = exp_q.pop_front();
                ok = 1'b1;
                if (e.mask[4] && state !== e.st)  ok = 1'b0;
                if (e.mask[3] && lane  !== e.ln)  ok = 1'b0;
                if (e.mask[2] && score !== e.sc)  ok = 1'b0;
                if (e.mask[1] && step  !== e.stp) ok = 1'b0;
                if (e.mask[0] && speed !== e.spd) ok = 1'b0;
                checks++;
                if (!ok) begin
                    errors++;
                    $display("FAIL %s cyc=%0d: got st=%0d lane=%0d score=%h step=%0b speed=%0d, want st=%0d lane=%0d score=%h step=%0b speed=%0d (mask %b)",
                             e.name, cyc, state, lane, score, step, speed,
                             e.st, e.ln, e.sc, e.stp, e.spd, e.mask);
                end
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not complete, %0d checks pending", exp_q.size());
        $fatal(1, "watchdog");
    end

    task automatic nxt();
        @(negedge clk25);
    endtask

    initial begin
        clr = 1'b0; left = 1'b0; right = 1'b0; start = 1'b0; ret = 1'b0;
        mode = 3'd1; collide = 1'b0;
        nxt();
        push(cyc + 1, "reset", M_ALL, ST_IDLE, 2'd1, 16'd0, 1'b0, 3'd1);
        nxt();

        // Start held 10 cycles at speed 3: one RUN entry, step every 4 edges.
        clr = 1'b1; mode = 3'd3;
        nxt();
        b = cyc;
        for (int k = 0; k <= 40; k++)
            push(b + 1 + k, "run_step", M_ALL, ST_RUN, 2'd1, 16'(k / 4),
                 (k > 0) && (k % 4 == 0), 3'd3);
        start = 1'b1;
        repeat (10) nxt();
        start = 1'b0;
        repeat (31) nxt();

        // Lane saturation and simultaneous left/right.
        for (int i = 0; i < 3; i++) begin
            left = 1'b1; push(cyc + 1, "lane_left", M_SL, ST_RUN, 2'd0, 16'd0, 1'b0, 3'd0);
            nxt(); left = 1'b0; nxt();
        end
        for (int i = 0; i < 4; i++) begin
            right = 1'b1;
            push(cyc + 1, "lane_right", M_SL, ST_RUN, (i == 0) ? 2'd1 : 2'd2, 16'd0, 1'b0, 3'd0);
            nxt(); right = 1'b0; nxt();
        end
        left = 1'b1; right = 1'b1;
        push(cyc + 1, "lane_both", M_SL, ST_RUN, 2'd2, 16'd0, 1'b0, 3'd0);
        nxt(); left = 1'b0; right = 1'b0;
        collide = 1'b1;
        push(cyc + 1, "collide", M_SL, ST_OVER, 2'd2, 16'd0, 1'b0, 3'd0);
        nxt(); collide = 1'b0;

        // Restart, reach score 5, pause with counter held at 1.
        start = 1'b1;
        b = cyc;
        for (int k = 0; k <= 21; k++)
            push(b + 1 + k, "pre_pause", M_ALL, ST_RUN, 2'd1, 16'(k / 4),
                 (k > 0) && (k % 4 == 0), 3'd3);
        nxt(); start = 1'b0;
        repeat (21) nxt();
        ret = 1'b1;
        push(cyc + 1, "pause_enter", M_ALL, ST_PAUSE, 2'd1, 16'd5, 1'b0, 3'd3);
        nxt(); ret = 1'b0;
        b = cyc;
        for (int j = 0; j < 100; j++)
            push(b + 1 + j, "pause_hold", M_ALL, ST_PAUSE, 2'd1, 16'd5, 1'b0, 3'd3);
        repeat (100) nxt();
        ret = 1'b1;
        b = cyc;
        push(b + 1, "resume", M_ALL, ST_RUN, 2'd1, 16'd5, 1'b0, 3'd3);
        push(b + 2, "resume_c2", M_ALL, ST_RUN, 2'd1, 16'd5, 1'b0, 3'd3);
        push(b + 3, "resume_c3", M_ALL, ST_RUN, 2'd1, 16'd5, 1'b0, 3'd3);
        push(b + 4, "resume_step", M_ALL, ST_RUN, 2'd1, 16'd6, 1'b1, 3'd3);
        nxt(); ret = 1'b0;
        repeat (3) nxt();

        // Collide beats ret; speed relatches in OVER; restart at speed 5.
        collide = 1'b1; ret = 1'b1;
        push(cyc + 1, "collide_ret", M_ALL, ST_OVER, 2'd1, 16'd6, 1'b0, 3'd3);
        nxt(); collide = 1'b0; ret = 1'b0; mode = 3'd5;
        push(cyc + 1, "over_speed", M_ALL, ST_OVER, 2'd1, 16'd6, 1'b0, 3'd5);
        nxt();
        start = 1'b1;
        b = cyc;
        for (int k = 0; k <= 4; k++)
            push(b + 1 + k, "fast_run", M_ALL, ST_RUN, 2'd1, 16'(k), k > 0, 3'd5);
        nxt(); start = 1'b0;
        repeat (4) nxt();
        left = 1'b1; collide = 1'b1;
        push(cyc + 1, "collide_left", M_ALL, ST_OVER, 2'd1, 16'd4, 1'b0, 3'd5);
        nxt(); left = 1'b0; collide = 1'b0;

        // Score saturation at 0xFFFF.
        start = 1'b1;
        b = cyc;
        push(b + 1, "sat_start", M_ALL, ST_RUN, 2'd1, 16'd0, 1'b0, 3'd5);
        push(b + 1 + 65534, "sat_fffe", M_ALL, ST_RUN, 2'd1, 16'hFFFE, 1'b1, 3'd5);
        push(b + 1 + 65535, "sat_ffff", M_ALL, ST_RUN, 2'd1, 16'hFFFF, 1'b1, 3'd5);
        push(b + 1 + 65536, "sat_hold", M_ALL, ST_RUN, 2'd1, 16'hFFFF, 1'b1, 3'd5);
        nxt(); start = 1'b0;
        repeat (65536) nxt();

        // Asynchronous clear between edges.
        @(posedge clk25);
        #2;
        push(cyc, "async_clr", M_ALL, ST_IDLE, 2'd1, 16'd0, 1'b0, 3'd1);
        clr = 1'b0;
        nxt();
        push(cyc + 1, "clr_held", M_ALL, ST_IDLE, 2'd1, 16'd0, 1'b0, 3'd1);
        nxt();
        clr = 1'b1;
        push(cyc + 1, "idle_after", M_ALL, ST_IDLE, 2'd1, 16'd0, 1'b0, 3'd5);
        nxt();
        mode = 3'd0; collide = 1'b1;
        push(cyc + 1, "mode0_collide", M_ALL, ST_IDLE, 2'd1, 16'd0, 1'b0, 3'd5);
        nxt();
        mode = 3'd7; collide = 1'b0;
        push(cyc + 1, "mode7", M_ALL, ST_IDLE, 2'd1, 16'd0, 1'b0, 3'd5);
        nxt();
        mode = 3'd2;
        push(cyc + 1, "mode2", M_ALL, ST_IDLE, 2'd1, 16'd0, 1'b0, 3'd2);
        nxt();

        // Speed 2 run, OVER -> IDLE keeps score, start beats ret in OVER.
        start = 1'b1;
        b = cyc;
        for (int k = 0; k <= 8; k++)
            push(b + 1 + k, "run_spd2", M_ALL, ST_RUN, 2'd1, 16'(k / 8), k == 8, 3'd2);
        nxt(); start = 1'b0;
        repeat (8) nxt();
        collide = 1'b1;
        push(cyc + 1, "over2", M_ALL, ST_OVER, 2'd1, 16'd1, 1'b0, 3'd2);
        nxt(); collide = 1'b0; ret = 1'b1;
        push(cyc + 1, "over_ret", M_ALL, ST_IDLE, 2'd1, 16'd1, 1'b0, 3'd2);
        nxt(); ret = 1'b0;
        push(cyc + 1, "idle_hold", M_ALL, ST_IDLE, 2'd1, 16'd1, 1'b0, 3'd2);
        nxt(); start = 1'b1;
        push(cyc + 1, "restart", M_ALL, ST_RUN, 2'd1, 16'd0, 1'b0, 3'd2);
        nxt(); start = 1'b0; collide = 1'b1;
        push(cyc + 1, "over3", M_ALL, ST_OVER, 2'd1, 16'd0, 1'b0, 3'd2);
        nxt(); collide = 1'b0; start = 1'b1; ret = 1'b1;
        push(cyc + 1, "start_wins", M_ALL, ST_RUN, 2'd1, 16'd0, 1'b0, 3'd2);
        nxt(); start = 1'b0; ret = 1'b0;
        repeat (3) nxt();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d snapshots never compared, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
